// File: rtl/counter_pkg.sv
// Shared types for the modulo counter family: counting-mode encoding and
// the mapping of the reserved encoding onto plain wrap behaviour.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP_ENC    = 2'd0;
  localparam logic [1:0] MODE_SAT_ENC     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT_ENC = 2'd2;
  localparam logic [1:0] MODE_RSVD_ENC    = 2'd3;

  typedef enum logic [1:0] {
    MODE_WRAP    = MODE_WRAP_ENC,
    MODE_SAT     = MODE_SAT_ENC,
    MODE_ONESHOT = MODE_ONESHOT_ENC,
    MODE_RSVD    = MODE_RSVD_ENC
  } mode_t;

  // The reserved encoding is treated exactly like WRAP everywhere.
  function automatic mode_t eff_mode(input mode_t m);
    return (m == MODE_RSVD) ? MODE_WRAP : m;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last
// one, so the counter steps once every PRESCALE enabled cycles. The count
// is held while en is low and restarts from 0 on clr.
module mod_counter_prescaler #(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next prescaler count: clear wins, otherwise advance on enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with wrap, saturate and one-shot
// modes, synchronous clear/load and an optional enable prescaler.
// The one-shot IDLE/RUN state is held directly in the busy flop.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 128,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  mode_t            mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             sat,
  output logic             busy
);

  // Reject illegal parameter combinations at elaboration.
  if ((MAX_COUNT < 1) ||
      (longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_max
    $error("mod_counter: MAX_COUNT must lie in 1 .. 2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be at least 1");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  mode_t            mode_e;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] restart;
  logic [WIDTH-1:0] q_move;
  logic             at_term;
  logic             tick;
  logic             start_ok;
  logic             step;

  // Load values above the terminal value are pulled down to it so q can
  // never leave the 0..MAX_COUNT range.
  function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  assign mode_e   = eff_mode(mode);
  assign term     = up ? MAX_Q : '0;
  assign restart  = up ? '0 : MAX_Q;
  assign at_term  = (q_q == term);
  assign q_move   = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
  assign start_ok = start && (mode_e == MODE_ONESHOT) && !busy_q;
  assign step     = en && tick && ((mode_e != MODE_ONESHOT) || busy_q);

  // The prescaler restarts whenever the count is re-seeded (clr, load or
  // an accepted start) so a fresh run always gets a full first interval.
  if (PRESCALE > 1) begin : g_prescale
    mod_counter_prescaler #(
      .PRESCALE (PRESCALE)
    ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr | load | start_ok),
      .en    (en),
      .tick  (tick)
    );
  end else begin : g_no_prescale
    assign tick = 1'b1;
  end

  // Next count, terminal pulse and run state, in priority order
  // clr > load > start > step.
  always_comb begin
    q_d    = q_q;
    tc_d   = 1'b0;
    busy_d = (mode_e == MODE_ONESHOT) ? busy_q : 1'b0;
    if (clr) begin
      q_d    = '0;
      busy_d = 1'b0;
    end else if (load) begin
      q_d = clamp_max(load_val);
    end else if (start_ok) begin
      q_d    = restart;
      busy_d = 1'b1;
    end else if (step) begin
      case (mode_e)
        MODE_SAT: begin
          if (!at_term) begin
            q_d = q_move;
          end
        end
        MODE_ONESHOT: begin
          // A run already sitting on the terminal (after a direction
          // change or a load) simply ends there.
          if (at_term) begin
            busy_d = 1'b0;
            tc_d   = 1'b1;
          end else begin
            q_d = q_move;
            if (q_move == term) begin
              busy_d = 1'b0;
              tc_d   = 1'b1;
            end
          end
        end
        default: begin
          if (at_term) begin
            q_d  = restart;
            tc_d = 1'b1;
          end else begin
            q_d = q_move;
          end
        end
      endcase
    end
  end

  // Count, terminal-pulse and run-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      tc_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tc_q   <= tc_d;
      busy_q <= busy_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign sat  = (mode_e == MODE_SAT) && at_term;

  // The count stays inside 0..MAX_COUNT.
  a_q_range : assert property (@(posedge clk) disable iff (!rst_n)
    q_q <= MAX_Q);

  // A terminal pulse lasts one cycle; two back-to-back pulses can only be
  // two separate events caused by a direction or mode change in between.
  a_tc_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    tc_q |=> (!tc_q || ($past(up) != $past(up, 2)) ||
              ($past(mode) != $past(mode, 2))));

  // A run ends only with its terminal pulse, a clear or leaving ONESHOT.
  a_busy_fall : assert property (@(posedge clk) disable iff (!rst_n)
    $fell(busy_q) |-> (tc_q || $past(clr) || ($past(mode_e) != MODE_ONESHOT)));

  c_wrap_up : cover property (@(posedge clk) disable iff (!rst_n)
    !clr && !load && step && (mode_e == MODE_WRAP) && at_term && up);

  c_wrap_down : cover property (@(posedge clk) disable iff (!rst_n)
    !clr && !load && step && (mode_e == MODE_WRAP) && at_term && !up);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three instances with different MAX_COUNT/PRESCALE
// share one stimulus stream; each is compared every cycle with a
// behavioural model, plus directed checks on key sequence points.
module tb_mod_counter;
  import counter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       en;
  logic       up;
  mode_t      mode;
  logic       load;
  logic [7:0] load_val;
  logic       start;

  logic [7:0] q_o    [3];
  logic       tc_o   [3];
  logic       sat_o  [3];
  logic       busy_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int q;
    int busy;
    int pre;
    int tc;
  } mst_t;

  mst_t ms [3];
  int   maxv [3] = '{128, 5, 200};
  int   prev [3] = '{1, 3, 2};

  mod_counter #(.WIDTH(8), .MAX_COUNT(128), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val), .start(start),
    .q(q_o[0]), .tc(tc_o[0]), .sat(sat_o[0]), .busy(busy_o[0]));

  mod_counter #(.WIDTH(8), .MAX_COUNT(5), .PRESCALE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val), .start(start),
    .q(q_o[1]), .tc(tc_o[1]), .sat(sat_o[1]), .busy(busy_o[1]));

  mod_counter #(.WIDTH(8), .MAX_COUNT(200), .PRESCALE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val), .start(start),
    .q(q_o[2]), .tc(tc_o[2]), .sat(sat_o[2]), .busy(busy_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge, straight from the counting rules:
  // mode 3 counts as WRAP, terminal is MAX going up and 0 going down.
  function automatic mst_t model_next(input mst_t s, input int maxc,
                                      input int presc, input int c,
                                      input int ld, input int lv,
                                      input int st, input int e,
                                      input int u, input int md);
    mst_t n;
    int   m, term, rs, dir, tick;
    m    = (md == 3) ? 0 : md;
    term = u ? maxc : 0;
    rs   = u ? 0 : maxc;
    dir  = u ? 1 : -1;
    tick = (s.pre == presc - 1);
    n    = s;
    n.tc = 0;
    if (m != 2) n.busy = 0;
    if (c != 0) begin
      n.q = 0; n.busy = 0; n.pre = 0;
    end else if (ld != 0) begin
      n.q = (lv > maxc) ? maxc : lv;
      n.pre = 0;
    end else if (st != 0 && m == 2 && s.busy == 0) begin
      n.q = rs; n.busy = 1; n.pre = 0;
    end else begin
      if (e != 0) n.pre = (s.pre + 1) % presc;
      if (e != 0 && tick != 0 && (m != 2 || s.busy != 0)) begin
        if (m == 0) begin
          if (s.q == term) begin n.q = rs; n.tc = 1; end
          else n.q = s.q + dir;
        end else if (m == 1) begin
          if (s.q != term) n.q = s.q + dir;
        end else begin
          if (s.q != term) n.q = s.q + dir;
          if (n.q == term) begin n.busy = 0; n.tc = 1; end
        end
      end
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) ms[i] = '{0, 0, 0, 0};
  endtask

  // One clock: advance the models on the edge, then compare all outputs.
  task automatic cycle();
    int esat;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) ms[i] = '{0, 0, 0, 0};
      else ms[i] = model_next(ms[i], maxv[i], prev[i], int'(clr), int'(load),
                              int'(load_val), int'(start), int'(en),
                              int'(up), int'(mode));
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      esat = (int'(mode) == 1) && (ms[i].q == (up ? maxv[i] : 0));
      chk($sformatf("q[%0d]", i), int'(q_o[i]), ms[i].q);
      chk($sformatf("tc[%0d]", i), int'(tc_o[i]), ms[i].tc);
      chk($sformatf("busy[%0d]", i), int'(busy_o[i]), ms[i].busy);
      chk($sformatf("sat[%0d]", i), int'(sat_o[i]), esat);
    end
  endtask

  task automatic idle_inputs();
    clr = 0; load = 0; start = 0; en = 0;
  endtask

  initial begin
    rst_n = 0; clr = 0; en = 0; up = 0; mode = MODE_SAT;
    load = 0; load_val = '0; start = 0;
    model_reset();
    #3;
    chk("rst_q", int'(q_o[0]), 0);
    chk("rst_tc", int'(tc_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_sat_down", int'(sat_o[0]), 1);
    mode = MODE_WRAP; up = 1;
    cycle();
    cycle();
    rst_n = 1;

    // Basic up count and wrap on MAX=128.
    en = 1;
    for (int k = 0; k < 128; k++) cycle();
    chk("basic_q128", int'(q_o[0]), 128);
    chk("basic_tc_before", int'(tc_o[0]), 0);
    cycle();
    chk("basic_wrap_q", int'(q_o[0]), 0);
    chk("basic_wrap_tc", int'(tc_o[0]), 1);
    cycle();
    chk("basic_after_q", int'(q_o[0]), 1);
    chk("basic_after_tc", int'(tc_o[0]), 0);

    // Down wrap and load clamp.
    idle_inputs(); load = 1; load_val = 8'd2;
    cycle();
    chk("down_load2", int'(q_o[0]), 2);
    load = 0; up = 0; en = 1;
    cycle(); chk("down_q1", int'(q_o[0]), 1);
    cycle(); chk("down_q0", int'(q_o[0]), 0);
    chk("down_tc_q0", int'(tc_o[0]), 0);
    cycle(); chk("down_wrap_q", int'(q_o[0]), 128);
    chk("down_wrap_tc", int'(tc_o[0]), 1);
    idle_inputs(); load = 1; load_val = 8'd200;
    cycle();
    chk("load_clamp_a", int'(q_o[0]), 128);
    chk("load_clamp_b", int'(q_o[1]), 5);

    // Saturate mode.
    idle_inputs(); mode = MODE_SAT; up = 1; load = 1; load_val = 8'd126;
    cycle();
    load = 0; en = 1;
    cycle(); chk("sat_q127", int'(q_o[0]), 127);
    chk("sat_flag127", int'(sat_o[0]), 0);
    cycle(); chk("sat_q128", int'(q_o[0]), 128);
    chk("sat_flag128", int'(sat_o[0]), 1);
    cycle(); chk("sat_hold", int'(q_o[0]), 128);
    chk("sat_tc", int'(tc_o[0]), 0);
    up = 0;
    cycle(); chk("sat_back", int'(q_o[0]), 127);
    chk("sat_flag_back", int'(sat_o[0]), 0);

    // One-shot on MAX=5, PRESCALE=3 with an ignored mid-run start.
    idle_inputs(); mode = MODE_ONESHOT; up = 1; start = 1;
    cycle();
    chk("os_busy", int'(busy_o[1]), 1);
    chk("os_q0", int'(q_o[1]), 0);
    start = 0; en = 1;
    for (int k = 1; k <= 15; k++) begin
      start = (k == 8);
      cycle();
      if (k == 8) begin
        chk("os_restart_ignored_q", int'(q_o[1]), 2);
        chk("os_restart_ignored_busy", int'(busy_o[1]), 1);
      end
    end
    start = 0;
    chk("os_end_q", int'(q_o[1]), 5);
    chk("os_end_tc", int'(tc_o[1]), 1);
    chk("os_end_busy", int'(busy_o[1]), 0);
    for (int k = 0; k < 3; k++) cycle();
    chk("os_hold_q", int'(q_o[1]), 5);
    chk("os_hold_tc", int'(tc_o[1]), 0);

    // clr and load on a wrapping cycle: clr wins, no tc.
    idle_inputs(); mode = MODE_WRAP; up = 1; load = 1; load_val = 8'd128;
    cycle();
    clr = 1; load = 1; en = 1; load_val = 8'd50;
    cycle();
    chk("coll_q", int'(q_o[0]), 0);
    chk("coll_tc", int'(tc_o[0]), 0);

    // Asynchronous reset in the middle of a one-shot run.
    idle_inputs(); mode = MODE_ONESHOT; up = 1; start = 1;
    cycle();
    start = 0; en = 1;
    for (int k = 0; k < 9; k++) cycle();
    chk("rstmid_pre_q", int'(q_o[1]), 3);
    rst_n = 0;
    #2;
    model_reset();
    chk("rstmid_q", int'(q_o[1]), 0);
    chk("rstmid_busy", int'(busy_o[1]), 0);
    cycle();
    rst_n = 1; mode = MODE_WRAP;
    cycle();
    chk("rstmid_resume", int'(q_o[0]), 1);

    // en gating with PRESCALE=2.
    idle_inputs(); clr = 1;
    cycle();
    clr = 0;
    for (int k = 0; k < 8; k++) begin
      en = (k % 2 == 0);
      cycle();
    end
    chk("gate_q", int'(q_o[2]), 2);

    // Randomised traffic.
    idle_inputs();
    for (int k = 0; k < 3000; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 39) == 0);
      load_val = 8'($urandom_range(0, 255));
      start    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) up = ~up;
      if ($urandom_range(0, 63) == 0) mode = mode_t'(2'($urandom_range(0, 3)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter with selectable wrap, saturate and one-shot modes, synchronous load/clear and an optional enable prescaler. It is the general-purpose successor of the fixed 8-bit wrap-at-MAX counter. It serves as a timer, event counter or timeout generator inside larger control blocks.

## Interface
- WIDTH, 8: counter width in bits.
- MAX_COUNT, 128: terminal value. Legal range 1 .. 2^WIDTH-1; elaboration fails otherwise.
- PRESCALE, 1: enabled cycles per count step. Legal range ≥1; 1 means a step on every enabled cycle.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down.
- mode  in  2  counter_pkg::mode_t: WRAP=0, SAT=1, ONESHOT=2; 3 is reserved and behaves as WRAP.
- load  in  1  synchronous load.
- load_val  in  WIDTH  load value.
- start  in  1  arms a one-shot run (ONESHOT mode only).
- q  out  WIDTH  count value (registered).
- tc  out  1  terminal-count pulse (registered, one cycle).
- sat  out  1  saturated indication (combinational).
- busy  out  1  one-shot run in progress (registered).

## Operation
- Terminal value is MAX_COUNT when up=1 and 0 when up=0. The restart value is the opposite end.
- Priority per edge: rst_n low > clr > load > start > step.
- clr: q←0, busy←0, prescaler←0.
- load: q←min(load_val, MAX_COUNT), prescaler←0. busy is unchanged.
- Step: taken when en=1 and the prescaler tick is high. In ONESHOT mode a step also requires busy=1.
- Prescaler: counts en cycles 0..PRESCALE-1 and ticks on PRESCALE-1. It is held while en=0.
- WRAP mode, step with q≠terminal: q moves ±1.
- WRAP mode, step with q=terminal: q←restart value and tc=1 next cycle.
- SAT mode, step with q≠terminal: q moves ±1.
- SAT mode, step with q=terminal: q holds and tc stays 0.
- sat = (mode==SAT) && (q==terminal).
- ONESHOT states are IDLE (busy=0) and RUN (busy=1).
- IDLE→RUN on start: q←restart value, prescaler←0.
- In RUN, each step moves q ±1. The step that makes q equal terminal returns to IDLE (busy←0) and sets tc=1 in the same edge.
- start while busy=1 is ignored.
- Changing mode away from ONESHOT forces busy←0 on the next edge.
- Direction change is allowed at any time and takes effect on the next step. Mid-run in ONESHOT, the run then ends at the new terminal.
- All arithmetic is WIDTH bits. q never exceeds MAX_COUNT.

## Timing
- Reset values: q=0, tc=0, busy=0. sat follows from these and the current inputs (1 only for mode=SAT, up=0).
- q updates one edge after the qualifying inputs are sampled. Latency is 1 cycle.
- tc is high for exactly one cycle: the cycle q first shows the wrapped value (WRAP) or the terminal value (ONESHOT).
- Back-to-back wraps with PRESCALE=1 produce tc once every MAX_COUNT+1 cycles.
- clr or load in the same cycle as a wrapping step suppresses both the step and tc.
- Reset asserted mid-run: all registers clear immediately (asynchronously). Counting resumes on the first edge after rst_n rises, with the prescaler at 0.

## Structure
- counter_pkg holds mode_t and the localparams for mode encodings.
- Sub-module mod_counter_prescaler: ports clk, rst_n, clr, en; output tick. It is instantiated only when PRESCALE>1; otherwise tick is tied to 1.
- The ONESHOT state is the busy flop; no separate FSM module is needed.
- Assertions are embedded in the module:
  - q ≤ MAX_COUNT.
  - tc is a single-cycle pulse.
  - busy falls only with tc, clr, a mode change or reset.
- Cover: a wrap in both directions.

## Test plan
- Reset/basic (WIDTH=8, MAX=128, WRAP, up): after release, q=0,1,…,128,0. tc=1 only in the cycle q=0 after 128.
- Down wrap: load 2, up=0. Sequence q=2,1,0,128 with tc at 128. Load 200 → q=128 (clamp).
- Saturate: mode=SAT, load 126, up. Sequence q=127,128,128… with sat=1 from q=128 and tc never asserted. Then up=0 gives 127 and sat=0.
- One-shot (MAX=5, PRESCALE=3): start pulse gives busy=1, q=0. q increments every 3 en cycles to 5. busy=0 and tc=1 together in the cycle q=5, then q holds. A second start mid-run is ignored.
- Collisions: load and clr asserted on the wrap cycle → clr wins, q=0, no tc. Reset pulsed mid-ONESHOT at q=3 → q=0, busy=0 immediately.
- en gating: en toggling 1/0 with PRESCALE=2 → q advances once per 2 enabled cycles and never on en=0 cycles.
